// File: rtl/bz_deserializer.sv
// bz_deserializer: router-to-core stage.
// Pops 11-bit router flits (bit 10 = tail) from a show-ahead egress FIFO and
// rebuilds 32-bit core words {route, code, payload}. A packet is a header
// flit followed by one or more 3-flit data groups. Every data group that
// does not end in a tail flit reuses the header's route.
// Optional build macro BZ_DESER_ERRCHK_EN enables reserved-bit/tail format
// checks, a sticky err flag and a DROP state. Without it err is tied 0.
module bz_deserializer #(
  parameter int NPCcode  = 7,
  parameter int NPCdata  = 20,
  parameter int NPCroute = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic [31:0] PC_out_channel_d,
  output logic        PC_out_channel_v,
  input  logic        PC_out_channel_a,
  output logic        err
);

  // The payload is built from two 10-bit flit halves, so it must be exactly 20 bits.
  if (NPCroute + NPCcode + NPCdata != 32 || NPCcode > 10 || NPCdata != 20) begin : g_bad_cfg
    $error("bz_deserializer: route+code+data must be 32, code<=10, data=20");
  end

  typedef enum logic [2:0] {
    HDR, D1, D2, D3
`ifdef BZ_DESER_ERRCHK_EN
    , DROP
`endif
  } state_t;

  state_t              state;
  logic [NPCroute-1:0] route_r;
  logic [NPCcode-1:0]  code_r;
  logic [9:0]          mid_r;

  // Pop whenever a flit is available. The last data flit also needs the
  // single output slot to be free or draining this cycle.
  always_comb begin
    fifo_rdreq = 1'b0;
    if (!reset && !fifo_empty)
      fifo_rdreq = (state != D3) || !PC_out_channel_v || PC_out_channel_a;
  end

`ifdef BZ_DESER_ERRCHK_EN
  logic fmt_bad;

  // Flag reserved bits set in the header/code flits, or a tail arriving
  // before the packet is complete.
  always_comb begin
    fmt_bad = 1'b0;
    case (state)
      HDR:     fmt_bad = |fifo_q[10:NPCroute];
      D1:      fmt_bad = |fifo_q[10:NPCcode];
      D2:      fmt_bad = fifo_q[10];
      default: fmt_bad = 1'b0;
    endcase
  end
`else
  assign err = 1'b0;
`endif

  // Flit-assembly FSM plus the registered output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= HDR;
      route_r          <= '0;
      code_r           <= '0;
      mid_r            <= '0;
      PC_out_channel_d <= '0;
      PC_out_channel_v <= 1'b0;
`ifdef BZ_DESER_ERRCHK_EN
      err              <= 1'b0;
`endif
    end else begin
      // The accepted word leaves the slot. A D3 pop below may refill it in the same cycle.
      if (PC_out_channel_v && PC_out_channel_a)
        PC_out_channel_v <= 1'b0;
      if (fifo_rdreq) begin
`ifdef BZ_DESER_ERRCHK_EN
        if (fmt_bad) begin
          err   <= 1'b1;
          // If the offending flit is itself a tail, the packet is already
          // over. Skip DROP so the next packet is not swallowed.
          state <= fifo_q[10] ? HDR : DROP;
        end else
`endif
        case (state)
          HDR: begin
            route_r <= fifo_q[NPCroute-1:0];
            state   <= D1;
          end
          D1: begin
            code_r <= fifo_q[NPCcode-1:0];
            state  <= D2;
          end
          D2: begin
            mid_r <= fifo_q[9:0];
            state <= D3;
          end
          D3: begin
            PC_out_channel_d <= {route_r, code_r, mid_r, fifo_q[9:0]};
            PC_out_channel_v <= 1'b1;
            state            <= fifo_q[10] ? HDR : D1;
          end
`ifdef BZ_DESER_ERRCHK_EN
          DROP: if (fifo_q[10]) state <= HDR;
`endif
          default: state <= HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bz_deserializer.sv
// Directed bench for bz_deserializer. A queue models the show-ahead FIFO.
// Words are captured whenever v&a holds at a clock edge.
module tb_bz_deserializer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] fifo_q = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rdreq;
  logic [31:0] d;
  logic        v;
  logic        a = 1'b1;
  logic        err;

  logic [10:0] fq[$];
  logic [31:0] got[$];
  bit          starve;
  int          npop, tests, fails;

  always #5 clk = ~clk;

  bz_deserializer dut (
    .clk(clk), .reset(reset), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .PC_out_channel_d(d), .PC_out_channel_v(v),
    .PC_out_channel_a(a), .err(err)
  );

  task automatic update_fifo();
    fifo_empty = starve || (fq.size() == 0);
    fifo_q     = (fq.size() != 0) ? fq[0] : 11'h0;
  endtask

  task automatic push(input logic [10:0] f);
    fq.push_back(f);
    update_fifo();
  endtask

  // One clock. Handshakes are sampled at the negedge, and the FIFO model updates just after the posedge.
  task automatic step();
    logic p, acc;
    logic [31:0] dd;
    @(negedge clk);
    p = fifo_rdreq; acc = v && a; dd = d;
    @(posedge clk); #1;
    if (p && fq.size() != 0) begin fq.delete(0); npop++; end
    if (acc) got.push_back(dd);
    update_fifo();
    #1;
  endtask

  task automatic test_reset();
    push(11'h005);
    #1;
    tests++; if (fifo_rdreq !== 1'b0) begin fails++; $display("FAIL reset_rdreq got=%b exp=0", fifo_rdreq); end
    step(); step();
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL reset_v got=%b exp=0", v); end
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_d got=%h exp=0", d); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (npop != 0) begin fails++; $display("FAIL reset_pop got=%0d exp=0", npop); end
    fq.delete(); update_fifo();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    a = 1'b1; got.delete(); npop = 0;
    push(11'h005); push(11'h02A); push(11'h155); push(11'h4AA);
    step(); step(); step();
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL single_early_v got=%b exp=0", v); end
    step();
    tests++; if (v !== 1'b1 || d !== 32'h2AA554AA) begin fails++; $display("FAIL single_word got v=%b d=%h exp v=1 d=2aa554aa", v, d); end
    tests++; if (npop != 4) begin fails++; $display("FAIL single_pops got=%0d exp=4", npop); end
    step();
    tests++; if (v !== 1'b0 || got.size() != 1) begin fails++; $display("FAIL single_drain got v=%b n=%0d exp v=0 n=1", v, got.size()); end
  endtask

  task automatic test_shared_header();
    got.delete(); npop = 0;
    push(11'h005); push(11'h02A); push(11'h155); push(11'h0AA);
    push(11'h001); push(11'h000); push(11'h401);
    for (int i = 0; i < 12; i++) step();
    tests++; if (npop != 7) begin fails++; $display("FAIL shared_pops got=%0d exp=7", npop); end
    tests++;
    if (got.size() != 2) begin fails++; $display("FAIL shared_count got=%0d exp=2", got.size()); end
    else if (got[0] !== 32'h2AA554AA || got[1] !== 32'h28100001) begin
      fails++; $display("FAIL shared_words got=%h,%h exp=2aa554aa,28100001", got[0], got[1]);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    got.delete(); npop = 0; a = 1'b0; bad = 0;
    push(11'h005); push(11'h02A); push(11'h155); push(11'h4AA);
    push(11'h005); push(11'h02A); push(11'h000); push(11'h401);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 10; i++) begin
      if (v !== 1'b1 || d !== 32'h2AA554AA) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold got %0d unstable cycles exp=0", bad); end
    tests++; if (npop != 7 || fifo_rdreq !== 1'b0) begin fails++; $display("FAIL bp_stall got pops=%0d rdreq=%b exp pops=7 rdreq=0", npop, fifo_rdreq); end
    a = 1'b1; #1;
    tests++; if (fifo_rdreq !== 1'b1) begin fails++; $display("FAIL bp_passthru_rdreq got=%b exp=1", fifo_rdreq); end
    step();
    tests++; if (v !== 1'b1 || d !== 32'h2AA00001 || npop != 8) begin fails++; $display("FAIL bp_next got v=%b d=%h pops=%0d exp v=1 d=2aa00001 pops=8", v, d, npop); end
    step();
    tests++;
    if (v !== 1'b0 || got.size() != 2) begin fails++; $display("FAIL bp_count got v=%b n=%0d exp v=0 n=2", v, got.size()); end
    else if (got[0] !== 32'h2AA554AA || got[1] !== 32'h2AA00001) begin
      fails++; $display("FAIL bp_words got=%h,%h exp=2aa554aa,2aa00001", got[0], got[1]);
    end
  endtask

  task automatic test_starvation();
    int bad;
    got.delete(); npop = 0; a = 1'b1; bad = 0;
    push(11'h005); push(11'h02A); push(11'h155); push(11'h4AA);
    for (int f = 0; f < 4; f++) begin
      starve = 1'b1; update_fifo(); #1;
      for (int i = 0; i < 5; i++) begin
        if (fifo_rdreq !== 1'b0) bad++;
        step();
      end
      if (npop != f) bad++;
      starve = 1'b0; update_fifo();
      step();
    end
    step(); step();
    tests++; if (bad != 0) begin fails++; $display("FAIL starve_rdreq got %0d violations exp=0", bad); end
    tests++;
    if (got.size() != 1) begin fails++; $display("FAIL starve_count got=%0d exp=1", got.size()); end
    else if (got[0] !== 32'h2AA554AA) begin fails++; $display("FAIL starve_word got=%h exp=2aa554aa", got[0]); end
  endtask

  task automatic test_reset_mid();
    got.delete(); npop = 0;
    push(11'h005); push(11'h02A);
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    push(11'h003); push(11'h07F); push(11'h3FF); push(11'h7FF);
    for (int i = 0; i < 7; i++) step();
    tests++;
    if (got.size() != 1) begin fails++; $display("FAIL rstmid_count got=%0d exp=1", got.size()); end
    else if (got[0] !== 32'h1FFFFFFF) begin fails++; $display("FAIL rstmid_word got=%h exp=1fffffff", got[0]); end
  endtask

  task automatic test_errchk();
    got.delete(); npop = 0;
    push(11'h045); push(11'h02A); push(11'h155); push(11'h4AA);
    push(11'h005); push(11'h02A); push(11'h155); push(11'h4AA);
    for (int i = 0; i < 14; i++) step();
    tests++; if (npop != 8) begin fails++; $display("FAIL err_pops got=%0d exp=8", npop); end
`ifdef BZ_DESER_ERRCHK_EN
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_flag got=%b exp=1", err); end
    tests++;
    if (got.size() != 1) begin fails++; $display("FAIL err_count got=%0d exp=1", got.size()); end
    else if (got[0] !== 32'h2AA554AA) begin fails++; $display("FAIL err_word got=%h exp=2aa554aa", got[0]); end
`else
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_flag got=%b exp=0", err); end
    tests++;
    if (got.size() != 2) begin fails++; $display("FAIL err_count got=%0d exp=2", got.size()); end
    else if (got[0] !== 32'h2AA554AA || got[1] !== 32'h2AA554AA) begin
      fails++; $display("FAIL err_words got=%h,%h exp=2aa554aa,2aa554aa", got[0], got[1]);
    end
`endif
    reset = 1'b1; step(); reset = 1'b0; step();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got=%b exp=0", err); end
  endtask

  initial begin
    starve = 1'b0; npop = 0; tests = 0; fails = 0;
    test_reset();
    test_single();
    test_shared_header();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    test_errchk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
